// File: rtl/oven_display_mux.sv
// rtl/oven_display_mux.sv - 4-digit multiplexed 7-seg driver with guard, snapshots, blinking dp; optional LEADING_ZERO_BLANK_EN
module oven_display_mux #(
  parameter int DIGIT_DIV = 12500,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       onOff,
  input  logic [3:0] minuteCountVal1,
  input  logic [3:0] minuteCountVal2,
  input  logic [3:0] hourCountVal1,
  input  logic [3:0] hourCountVal2,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_DIV - 1);
  localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0]     slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [3:0][3:0]   snap_q, snap_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_tick;
  logic              blink_wrap;
  logic              in_guard;
  logic              dark;
  logic [3:0]        digit;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_tick  = (slot_q == SLOT_LAST);
    slot_d     = slot_tick ? '0 : slot_q + SW'(1);
    idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;

    blink_wrap = (blink_q == BLINK_LAST);
    blink_d    = blink_wrap ? '0 : blink_q + BW'(1);
    phase_d    = phase_q ^ blink_wrap;

    // All four digits latch together at the end of a full scan to avoid tearing
    snap_d = (slot_tick && idx_q == 2'd3)
             ? {hourCountVal2, hourCountVal1, minuteCountVal2, minuteCountVal1}
             : snap_q;

    in_guard = (slot_q < GUARD_END);
    digit    = snap_q[idx_q];
    dark     = !onOff || in_guard;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 2'd3 && snap_q[3] == 4'd0) dark = 1'b1;
`endif

    anode_d = 4'b1111;
    if (!dark) anode_d[idx_q] = 1'b0;
    seg_d = onOff ? dec7(digit) : 7'b1111111;
    dp_d  = !(onOff && idx_q == 2'd2 && !in_guard && phase_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      idx_q   <= 2'd0;
      blink_q <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_oven_display_mux.sv
// tb/tb_oven_display_mux.sv - randomized self-checking bench for oven_display_mux against a cycle-count reference model
module tb_oven_display_mux;

  localparam int DD = 8;
  localparam int GD = 2;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       onOff;
  logic [3:0] m1, m2, h1, h2;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;
  int c;
  logic [3:0] snap [4];

  oven_display_mux #(.DIGIT_DIV(DD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .onOff(onOff),
    .minuteCountVal1(m1), .minuteCountVal2(m2),
    .hourCountVal1(h1), .hourCountVal2(h2),
    .anode(anode), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: ref_seg = 7'b1000000;  4'd1: ref_seg = 7'b1111001;
      4'd2: ref_seg = 7'b0100100;  4'd3: ref_seg = 7'b0110000;
      4'd4: ref_seg = 7'b0011001;  4'd5: ref_seg = 7'b0010010;
      4'd6: ref_seg = 7'b0000010;  4'd7: ref_seg = 7'b1111000;
      4'd8: ref_seg = 7'b0000000;  4'd9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b0111111;
    endcase
  endfunction

  task automatic check_blank(input string tag);
    tests++;
    assert (anode === 4'b1111) else begin fails++; $error("FAIL %s anode obs=%b exp=1111", tag, anode); end
    tests++;
    assert (seg === 7'b1111111) else begin fails++; $error("FAIL %s seg obs=%b exp=1111111", tag, seg); end
    tests++;
    assert (dp === 1'b1) else begin fails++; $error("FAIL %s dp obs=%b exp=1", tag, dp); end
  endtask

  // One clock: c counts edges since reset release; outputs after edge c reflect state c
  task automatic cycle();
    int slot, idx, cc;
    bit guard, seg_vis;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    cc    = c;
    slot  = c % DD;
    idx   = (c / DD) % 4;
    guard = (slot < GD);
    ea = 4'b1111;
    if (onOff && !guard) ea[idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && snap[3] == 4'd0) ea = 4'b1111;
`endif
    es = onOff ? ref_seg(snap[idx]) : 7'b1111111;
    seg_vis = !onOff || (ea != 4'b1111);
    ed = !(onOff && idx == 2 && !guard && ((c / BD) % 2 == 1));
    if (c % (4 * DD) == 4 * DD - 1) begin
      snap[0] = m1; snap[1] = m2; snap[2] = h1; snap[3] = h2;
    end
    c++;
    @(posedge clk);
    #1;
    tests++;
    assert (anode === ea) else begin fails++; $error("FAIL anode c=%0d obs=%b exp=%b", cc, anode, ea); end
    if (seg_vis) begin
      tests++;
      assert (seg === es) else begin fails++; $error("FAIL seg c=%0d obs=%b exp=%b", cc, seg, es); end
    end
    tests++;
    assert (dp === ed) else begin fails++; $error("FAIL dp c=%0d obs=%b exp=%b", cc, dp, ed); end
  endtask

  task automatic rand_digit();
    case ($urandom_range(0, 3))
      0: m1 = 4'($urandom_range(0, 15));
      1: m2 = 4'($urandom_range(0, 15));
      2: h1 = 4'($urandom_range(0, 15));
      default: h2 = 4'($urandom_range(0, 15));
    endcase
  endtask

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; onOff = 1'b1;
    m1 = 4'd1; m2 = 4'd2; h1 = 4'd3; h2 = 4'd4;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_blank("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    repeat (64) cycle();
    repeat (10) cycle();
    m1 = 4'd9;
    repeat (54) cycle();
    h1 = 4'hC;
    repeat (64) cycle();

    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 7) == 0) rand_digit();
      cycle();
    end

    onOff = 1'b0;
    repeat (40) cycle();
    onOff = 1'b1;
    repeat (64) cycle();

    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 5) == 0) rand_digit();
      if ($urandom_range(0, 15) == 0) onOff = ~onOff;
      cycle();
    end
    onOff = 1'b1;

    repeat (3) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check_blank("midreset");
    h2 = 4'd0;
    m1 = 4'($urandom_range(0, 9));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (96) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oven_display_mux.md
Name: oven_display_mux

Overview:
Downstream consumer of the oven time-of-day counter. Takes the four BCD time digits and drives a 4-digit, common-anode, multiplexed seven-segment display. Adds anti-ghosting guard time, tear-free digit snapshots, a blinking hours/minutes separator, and blanking when the oven is off.

Parameters:
DIGIT_DIV, 12500, clk cycles per digit slot (4 kHz slot rate at 50 MHz); must be > GUARD+1
GUARD, 16, clk cycles at start of each slot with all anodes off
BLINK_DIV, 25000000, clk cycles per separator half-period (1 Hz blink at 50 MHz)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
onOff  in  1  1 = display enabled, 0 = display blanked
minuteCountVal1  in  4  minutes ones digit, BCD
minuteCountVal2  in  4  minutes tens digit, BCD
hourCountVal1  in  4  hours ones digit, BCD
hourCountVal2  in  4  hours tens digit, BCD
anode  out  4  digit enables, active-low; bit i = scan index i
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  separator segment, active-low

Behaviour:
- Reset (async assert, sync release): slot counter 0, scan index 0, blink counter 0, blink phase 0, snapshots 0, anode 4'b1111, seg 7'b1111111, dp 1.
- Slot counter: counts 0..DIGIT_DIV-1, wraps to 0; tick = (count == DIGIT_DIV-1).
- Scan index: 2 bits; increments on tick, wraps 3->0. Mapping: 0 = minuteCountVal1, 1 = minuteCountVal2, 2 = hourCountVal1, 3 = hourCountVal2.
- Snapshot: on a tick with index == 3, all four inputs latch together. Displayed digits come only from snapshots, never from the live inputs, so there is no tearing mid-scan. Input changes become visible at the next scan start.
- Guard: while slot count < GUARD, anode = 4'b1111. Otherwise only the anode for the current index is driven 0.
- Outputs are registered: anode/seg/dp reflect the counter state of the previous cycle (1-cycle latency).
- Decode (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10..15 show a dash, 0111111.
- Blink: blink counter counts 0..BLINK_DIV-1; its wrap toggles the blink phase. dp = 0 only when the index is 2, the slot is outside guard, blink phase = 1, and onOff = 1. Otherwise dp = 1.
- onOff = 0: anode 4'b1111, dp 1, seg 7'b1111111. All counters and snapshots keep running, so re-enabling resumes mid-scan with no restart.
- onOff change: takes effect on outputs 1 cycle later.
- Reset mid-scan: outputs blank immediately (async). Scanning restarts at index 0. The first snapshot after reset is taken at the end of the first full scan; until then all digits show 0.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: when the hourCountVal2 snapshot == 0, the index-3 slot keeps anode = 4'b1111 (digit dark); timing is unchanged.
- Undefined: a zero in hours tens is displayed as "0".

Test Plan:
1. All tests use DIGIT_DIV=8, GUARD=2, BLINK_DIV=64. Reset release with inputs 1,2,3,4 (min1, min2, hr1, hr2) -> anode sequence 1110, 1101, 1011, 0111 repeating every 32 cycles, each slot with 2 guard cycles of 1111. First scan shows "0" on all digits; second scan seg = 1111001, 0100100, 0110000, 0011001.
2. Change minuteCountVal1 from 1 to 9 mid-scan at index 1 -> the digit-0 seg stays 1111001 for the rest of that scan and reads 0010000 from the next scan.
3. Drive hourCountVal1 = 4'hC -> the index-2 slot shows seg 0111111.
4. Blink: observe 256 cycles -> dp pulses 0 only in non-guard cycles of index-2 slots, only in alternate 64-cycle phases; dp = 1 at all other indices.
5. onOff = 0 for 40 cycles, then 1 -> anode = 1111 and dp = 1 from 1 cycle after the fall. After the rise the scan index continues from its running value, with no reset to 0.
6. Assert rst_n low mid-slot -> anode = 1111, seg = 1111111, dp = 1 in the same cycle. With LEADING_ZERO_BLANK_EN and hourCountVal2 = 0, the index-3 slot anode stays 1111 after re-release.
